// File: rtl/fir_pkg.sv
// Shared definitions for the fir datapath and its upstream fir_feeder sequencer.
package fir_pkg;

  localparam int NTAPS_C  = 16;
  localparam int NGROUP_C = 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WIND = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_WAIT = 3'd4,
    ST_RESP = 3'd5
  } fir_feeder_state_t;

endpackage

// File: rtl/fir_feeder.sv
// Serialises coefficient/sample streams onto fir's wind/load/in_valid interface
// and returns one result per sample. Optional WAIT watchdog: FIR_FEEDER_TIMEOUT_EN.
module fir_feeder
  import fir_pkg::*;
#(
  parameter int DW      = 16,
  parameter int NTAPS   = NTAPS_C,
  parameter int NGROUP  = NGROUP_C,
  parameter int TIMEOUT = 32
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          coef_valid,
  output logic          coef_ready,
  input  logic [DW-1:0] coef_data,
  input  logic          samp_valid,
  output logic          samp_ready,
  input  logic [DW-1:0] samp_data,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          fir_wind,
  output logic          fir_load,
  output logic [DW-1:0] fir_data,
  output logic          fir_in_valid,
  input  logic          fir_out_valid,
  input  logic [DW-1:0] fir_out,
  output logic          coefs_loaded,
  output logic          busy,
  output logic          err
);

  localparam int TW = $clog2(NTAPS + 1);
  localparam int GW = $clog2(NGROUP + 1);

  if (NTAPS < 2)   begin : g_bad_ntaps   $error("NTAPS must be >= 2");   end
  if (NGROUP < 1)  begin : g_bad_ngroup  $error("NGROUP must be >= 1");  end
  if (TIMEOUT < 1) begin : g_bad_timeout $error("TIMEOUT must be >= 1"); end

  fir_feeder_state_t state;
  logic [TW-1:0]     tap_cnt;
  logic [GW-1:0]     grp_cnt;
  logic [DW-1:0]     samp_q;
  logic [DW-1:0]     res_q;
  logic              loaded_q;
  logic              coef_acc;
  logic              samp_acc;

  // coef_ready is the only handshake that is high in IDLE, so it alone needs
  // masking to keep every output at 0 while reset is held.
  always_comb begin
    coef_ready   = !rstb && (state == ST_IDLE || state == ST_WIND);
    samp_ready   = (state == ST_IDLE) && loaded_q && !coef_valid;
    coef_acc     = coef_ready && coef_valid;
    samp_acc     = samp_ready && samp_valid;
    fir_wind     = coef_acc;
    fir_load     = (state == ST_LOAD);
    fir_in_valid = (state == ST_RUN);
    res_valid    = (state == ST_RESP);
    busy         = (state != ST_IDLE);
    fir_data     = '0;
    if (fir_wind)      fir_data = coef_data;
    else if (fir_load) fir_data = samp_q;
  end

  assign res_data     = res_q;
  assign coefs_loaded = loaded_q;

`ifdef FIR_FEEDER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wait_cnt;
  logic          err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_ff @(negedge clk or posedge rstb) begin
    if (rstb) begin
      state    <= ST_IDLE;
      tap_cnt  <= '0;
      grp_cnt  <= '0;
      samp_q   <= '0;
      res_q    <= '0;
      loaded_q <= 1'b0;
`ifdef FIR_FEEDER_TIMEOUT_EN
      wait_cnt <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (coef_acc) begin
            tap_cnt <= TW'(1);
            state   <= ST_WIND;
          end else if (samp_acc) begin
            samp_q <= samp_data;
            state  <= ST_LOAD;
          end
        end
        ST_WIND: begin
          if (coef_acc) begin
            if (tap_cnt == TW'(NTAPS - 1)) begin
              tap_cnt  <= '0;
              loaded_q <= 1'b1;
              state    <= ST_IDLE;
            end else begin
              tap_cnt <= tap_cnt + TW'(1);
            end
          end
        end
        ST_LOAD: begin
          grp_cnt <= '0;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          // fir_out_valid is deliberately not looked at until WAIT.
          if (grp_cnt == GW'(NGROUP - 1)) begin
            grp_cnt <= '0;
            state   <= ST_WAIT;
`ifdef FIR_FEEDER_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else begin
            grp_cnt <= grp_cnt + GW'(1);
          end
        end
        ST_WAIT: begin
          if (fir_out_valid) begin
            res_q <= fir_out;
            state <= ST_RESP;
          end
`ifdef FIR_FEEDER_TIMEOUT_EN
          else if (wait_cnt == WW'(TIMEOUT - 1)) begin
            err_q    <= 1'b1;
            wait_cnt <= '0;
            state    <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
`endif
        end
        ST_RESP: begin
          if (res_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_feeder.sv
// Directed, table-driven bench for fir_feeder; the fir side is stubbed by the
// per-cycle fir_out_valid/fir_out columns of the vector table.
module tb_fir_feeder;
  import fir_pkg::*;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rstb;
  logic          coef_valid, coef_ready;
  logic [DW-1:0] coef_data;
  logic          samp_valid, samp_ready;
  logic [DW-1:0] samp_data;
  logic          res_valid, res_ready;
  logic [DW-1:0] res_data;
  logic          fir_wind, fir_load, fir_in_valid, fir_out_valid;
  logic [DW-1:0] fir_data, fir_out;
  logic          coefs_loaded, busy, err;

  fir_feeder #(.DW(DW), .NTAPS(16), .NGROUP(4), .TIMEOUT(32)) dut (
    .clk(clk), .rstb(rstb),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .samp_valid(samp_valid), .samp_ready(samp_ready), .samp_data(samp_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .fir_wind(fir_wind), .fir_load(fir_load), .fir_data(fir_data),
    .fir_in_valid(fir_in_valid), .fir_out_valid(fir_out_valid), .fir_out(fir_out),
    .coefs_loaded(coefs_loaded), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // {cr, sr, rv, rd[16], fw, fl, fd[16], fiv, cl, busy, err}
  typedef logic [40:0] obs_t;

  typedef struct {
    logic          cv;
    logic [DW-1:0] cd;
    logic          sv;
    logic [DW-1:0] sd;
    logic          rr;
    logic          fov;
    logic [DW-1:0] fo;
    obs_t          exp;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic obs_t mk(logic cr, logic sr, logic rv, logic [DW-1:0] rd,
                              logic fw, logic fl, logic [DW-1:0] fd, logic fiv,
                              logic cl, logic bz, logic er);
    return {cr, sr, rv, rd, fw, fl, fd, fiv, cl, bz, er};
  endfunction

  function automatic obs_t obs();
    return {coef_ready, samp_ready, res_valid, res_data, fir_wind, fir_load,
            fir_data, fir_in_valid, coefs_loaded, busy, err};
  endfunction

  task automatic add(logic cv, logic [DW-1:0] cd, logic sv, logic [DW-1:0] sd,
                     logic rr, logic fov, logic [DW-1:0] fo, obs_t e);
    vec_t v;
    v.cv = cv; v.cd = cd; v.sv = sv; v.sd = sd; v.rr = rr; v.fov = fov; v.fo = fo;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(logic cv, logic [DW-1:0] cd, logic sv, logic [DW-1:0] sd,
                       logic rr, logic fov, logic [DW-1:0] fo);
    coef_valid = cv; coef_data = cd; samp_valid = sv; samp_data = sd;
    res_ready = rr; fir_out_valid = fov; fir_out = fo;
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Inputs change 1 time unit after posedge, outputs are sampled 1 unit later;
  // the DUT registers on the following negedge.
  task automatic cyc_drive(logic cv, logic [DW-1:0] cd, logic sv, logic [DW-1:0] sd,
                           logic rr, logic fov, logic [DW-1:0] fo);
    @(posedge clk);
    #1 drive(cv, cd, sv, sd, rr, fov, fo);
    #1;
  endtask

  initial begin
    // Main scenario: weight load with a gap while a sample is already offered,
    // one sample with backpressure, then a back-to-back sample.
    for (int k = 1; k <= 16; k++) begin
      if (k == 9)
        add(0, 0, 1, 16'h00A5, 0, 0, 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      add(1, 16'(k), 1, 16'h00A5, 0, 0, 0,
          mk(1, 0, 0, 0, 1, 0, 16'(k), 0, 0, (k != 1), 0));
    end
    add(0, 0, 1, 16'h00A5, 0, 0, 0, mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 1, 16'h00A5, 0, 1, 1, 0));
    for (int r = 0; r < 4; r++)
      add(0, 0, 0, 0, 0, (r == 2), 16'hDEAD, mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
    for (int w = 0; w < 5; w++)
      add(0, 0, 0, 0, 0, (w == 4), (w == 4) ? 16'h1234 : 16'h0,
          mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    for (int b = 0; b < 6; b++)
      add(0, 0, 1, 16'h0007, (b == 5), 0, 0, mk(0, 0, 1, 16'h1234, 0, 0, 0, 0, 1, 1, 0));
    add(0, 0, 1, 16'h0003, 0, 0, 0, mk(1, 1, 0, 16'h1234, 0, 0, 0, 0, 1, 0, 0));
    add(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 16'h1234, 0, 1, 16'h0003, 0, 1, 1, 0));
    for (int r = 0; r < 4; r++)
      add(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 16'h1234, 0, 0, 0, 1, 1, 1, 0));
    add(0, 0, 0, 0, 0, 1, 16'h0042, mk(0, 0, 0, 16'h1234, 0, 0, 0, 0, 1, 1, 0));
    add(0, 0, 0, 0, 1, 0, 0, mk(0, 0, 1, 16'h0042, 0, 0, 0, 0, 1, 1, 0));
    add(0, 0, 0, 0, 0, 0, 0, mk(1, 1, 0, 16'h0042, 0, 0, 0, 0, 1, 0, 0));

    // Reset state, with coef_valid offered to catch an ungated coef_ready.
    rstb = 1'b1;
    drive(1, 16'hFFFF, 1, 16'hFFFF, 0, 0, 0);
    #2 chk("reset_outputs", 64'(obs()), 64'(0));

    @(posedge clk);
    #1 rstb = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc_drive(vecs[i].cv, vecs[i].cd, vecs[i].sv, vecs[i].sd,
                vecs[i].rr, vecs[i].fov, vecs[i].fo);
      n_chk++;
      if (obs() !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d: got %h, expected %h (cr sr rv rd fw fl fd fiv cl busy err)",
                 i, obs(), vecs[i].exp);
      end
    end

    // Reset in the second RUN cycle: everything drops at once, weights forgotten.
    cyc_drive(0, 0, 1, 16'h0005, 0, 0, 0);
    chk("rst_seq_accept", 64'(samp_ready), 64'(1));
    cyc_drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_seq_load", 64'(fir_load), 64'(1));
    cyc_drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst_seq_run1", 64'(fir_in_valid), 64'(1));
    cyc_drive(0, 0, 1, 16'h0005, 0, 0, 0);
    chk("rst_seq_run2", 64'(fir_in_valid), 64'(1));
    rstb = 1'b1;
    #1 chk("rst_mid_run_outputs", 64'(obs()), 64'(0));
    cyc_drive(0, 0, 1, 16'h0005, 0, 0, 0);
    rstb = 1'b0;
    cyc_drive(0, 0, 1, 16'h0005, 0, 0, 0);
    chk("post_rst_refuse", 64'({samp_ready, coefs_loaded, busy}), 64'(3'b000));
    cyc_drive(0, 0, 1, 16'h0005, 0, 0, 0);
    chk("post_rst_idle", 64'({samp_ready, busy, fir_load}), 64'(3'b000));

`ifdef FIR_FEEDER_TIMEOUT_EN
    begin
      logic saw_rv;
      saw_rv = 1'b0;
      for (int k = 1; k <= 16; k++)
        cyc_drive(1, 16'(k), 0, 0, 0, 0, 0);
      cyc_drive(0, 0, 1, 16'h0055, 0, 0, 0);
      chk("to_accept", 64'({samp_ready, coefs_loaded}), 64'(2'b11));
      cyc_drive(0, 0, 0, 0, 0, 0, 0);
      for (int r = 0; r < 4; r++)
        cyc_drive(0, 0, 0, 0, 0, 0, 0);
      for (int w = 0; w < 32; w++) begin
        cyc_drive(0, 0, 0, 0, 1, 0, 0);
        if (res_valid) saw_rv = 1'b1;
        if (!busy || err) begin
          n_chk++;
          n_fail++;
          $display("FAIL to_wait%0d: busy=%0b err=%0b, expected busy=1 err=0", w, busy, err);
        end
      end
      cyc_drive(0, 0, 0, 0, 1, 0, 0);
      chk("to_abort", 64'({err, busy, res_valid, saw_rv}), 64'(4'b1000));
      cyc_drive(0, 0, 0, 0, 1, 0, 0);
      chk("to_sticky", 64'({err, busy}), 64'(2'b10));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Hard bound so the run always ends.
  initial begin
    #50000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

endmodule
